// File: rtl/button_event_decoder_if.sv
// Button event decoder bus: the enable and debounced button level going in,
// and the decoded event pulses and status levels coming back out.
interface button_event_decoder_if;
  logic en;
  logic pb_debounced;
  logic short_press;
  logic long_press;
  logic double_press;
  logic long_held;
  logic busy;

  modport master (
    output en,
    output pb_debounced,
    input  short_press,
    input  long_press,
    input  double_press,
    input  long_held,
    input  busy
  );

  modport slave (
    input  en,
    input  pb_debounced,
    output short_press,
    output long_press,
    output double_press,
    output long_held,
    output busy
  );
endinterface

// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced button level into single-cycle
// short / long / double press events using one saturating timer and a
// five-state FSM. Every output comes straight from a flop.
module button_event_decoder #(
  parameter int unsigned CLKFREQ = 32'd1000,
  parameter int unsigned LONG_MS = 32'd1000,
  parameter int unsigned DBL_MS  = 32'd300
) (
  input  logic                         clk,
  input  logic                         reset_n,
  button_event_decoder_if.slave        bus
);

  localparam int unsigned LONG_TICKS = (LONG_MS * CLKFREQ) / 32'd1000;
  localparam int unsigned DBL_TICKS  = (DBL_MS * CLKFREQ) / 32'd1000;
  localparam int unsigned MAX_TICKS  = (LONG_TICKS > DBL_TICKS) ? LONG_TICKS : DBL_TICKS;
  localparam int unsigned TW         = $clog2(MAX_TICKS + 32'd1);

  typedef logic [TW-1:0] timer_t;

  // Timer value seen on the edge that completes each threshold.
  localparam timer_t LONG_LAST = TW'(LONG_TICKS - 32'd1);
  localparam timer_t DBL_LAST  = TW'(DBL_TICKS - 32'd1);
  localparam timer_t TIMER_ONE = TW'(32'd1);
  localparam timer_t TIMER_MAX = {TW{1'b1}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  state_t state_q, state_d;
  timer_t timer_q, timer_d;
  logic   short_q, short_d;
  logic   long_q, long_d;
  logic   double_q, double_d;
  logic   held_q, held_d;
  logic   busy_q, busy_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic timer_t sat_inc(input timer_t t);
    timer_t r;
    if (t == TIMER_MAX) begin
      r = t;
    end else begin
      r = t + TIMER_ONE;
    end
    return r;
  endfunction

  // Next-state, timer and registered-output decode; disable overrides all.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.pb_debounced) begin
            state_d = PRESS1;
            timer_d = TIMER_ONE;
          end else begin
            timer_d = '0;
          end
        end
        PRESS1: begin
          if (bus.pb_debounced) begin
            if (timer_q >= LONG_LAST) begin
              state_d = LONG_HELD;
              long_d  = 1'b1;
            end else begin
              state_d = PRESS1;
            end
            timer_d = sat_inc(timer_q);
          end else begin
            // Release wins even on the threshold edge; the release edge
            // is the first low sample of the double-press window.
            state_d = WAIT2;
            timer_d = TIMER_ONE;
          end
        end
        LONG_HELD: begin
          if (bus.pb_debounced) begin
            state_d = LONG_HELD;
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end
        WAIT2: begin
          // A press on the expiry edge still counts as the second press.
          if (bus.pb_debounced) begin
            state_d  = PRESS2;
            double_d = 1'b1;
          end else if (timer_q >= DBL_LAST) begin
            state_d = IDLE;
            short_d = 1'b1;
            timer_d = '0;
          end else begin
            state_d = WAIT2;
            timer_d = sat_inc(timer_q);
          end
        end
        PRESS2: begin
          if (bus.pb_debounced) begin
            state_d = PRESS2;
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
    held_d = (state_d == LONG_HELD);
  end

  // State, timer and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      held_q   <= held_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_press = double_q;
  assign bus.long_held    = held_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder (LONG_TICKS=8, DBL_TICKS=4).
// Stimulus pushes the hand-computed event and the edge number it is decided
// on; a forked monitor pops and compares whenever a pulse output is high.
module tb_button_event_decoder;

  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_DOUBLE = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_vec;
  int   n_miss;
  ev_t  exp_q[$];

  button_event_decoder_if bus_if ();

  button_event_decoder #(
    .CLKFREQ(32'd1000),
    .LONG_MS(32'd8),
    .DBL_MS (32'd4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Hold pb for n rising edges; returns 1 ns after the last edge.
  task automatic drive(input logic pb, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.pb_debounced = pb;
      @(posedge clk);
      cyc = cyc + 1;
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec = n_vec + 1;
    if (act != exp_v) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic int outs();
    return {27'd0, bus_if.busy, bus_if.long_held, bus_if.short_press,
            bus_if.long_press, bus_if.double_press};
  endfunction

  task automatic monitor_loop();
    int  k;
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus_if.short_press || bus_if.long_press || bus_if.double_press) begin
        n_vec = n_vec + 1;
        k = bus_if.short_press ? K_SHORT : (bus_if.long_press ? K_LONG : K_DOUBLE);
        if ((32'(bus_if.short_press) + 32'(bus_if.long_press) + 32'(bus_if.double_press)) > 1) begin
          n_miss = n_miss + 1;
          $display("FAIL onehot: s=%0b l=%0b d=%0b at edge %0d", bus_if.short_press,
                   bus_if.long_press, bus_if.double_press, cyc);
        end else if (exp_q.size() == 0) begin
          n_miss = n_miss + 1;
          $display("FAIL unexpected_pulse: got kind %0d at edge %0d, expected none", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.cyc != cyc) begin
            n_miss = n_miss + 1;
            $display("FAIL event: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                     k, cyc, e.kind, e.cyc);
          end
        end
      end
    end
  endtask

  initial begin
    int b;
    cyc    = 0;
    n_vec  = 0;
    n_miss = 0;
    reset_n = 1'b0;
    bus_if.en = 1'b1;
    bus_if.pb_debounced = 1'b0;
    fork
      monitor_loop();
    join_none
    #1;
    chk("reset_outs", outs(), 0);
    drive(1'b0, 2);
    reset_n = 1'b1;
    drive(1'b0, 2);
    chk("idle_outs", outs(), 0);

    // Short press: 3 high, release on b+4, window expires on b+7.
    b = cyc;
    push(K_SHORT, b + 7);
    drive(1'b1, 3);
    chk("short_busy_pressed", 32'(bus_if.busy), 1);
    drive(1'b0, 3);
    chk("short_busy_window", 32'(bus_if.busy), 1);
    drive(1'b0, 1);
    chk("short_busy_after", 32'(bus_if.busy), 0);
    drive(1'b0, 2);

    // Long press: 20 high, long decided on the 8th high edge.
    b = cyc;
    push(K_LONG, b + 8);
    drive(1'b1, 7);
    chk("long_held_early", 32'(bus_if.long_held), 0);
    drive(1'b1, 13);
    chk("long_held_level", 32'(bus_if.long_held), 1);
    drive(1'b0, 1);
    chk("long_release_outs", outs(), 0);
    drive(1'b0, 6);

    // Double press: high 2, low 2, high 10, low.
    b = cyc;
    push(K_DOUBLE, b + 5);
    drive(1'b1, 2);
    drive(1'b0, 2);
    drive(1'b1, 10);
    chk("double_busy_press2", 32'(bus_if.busy), 1);
    drive(1'b0, 1);
    chk("double_busy_after", 32'(bus_if.busy), 0);
    drive(1'b0, 6);

    // Window boundary: 4 low edges -> short; new press starts while the
    // short pulse is high, then 3 lows and a rise -> double.
    b = cyc;
    push(K_SHORT, b + 6);
    push(K_DOUBLE, b + 12);
    drive(1'b1, 2);
    drive(1'b0, 4);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 1);
    chk("boundary_busy_after", 32'(bus_if.busy), 0);
    drive(1'b0, 6);

    // Threshold: 7-cycle press is short, 8-cycle press is long.
    b = cyc;
    push(K_SHORT, b + 11);
    drive(1'b1, 7);
    drive(1'b0, 6);
    b = cyc;
    push(K_LONG, b + 8);
    drive(1'b1, 8);
    chk("thresh_long_held", 32'(bus_if.long_held), 1);
    drive(1'b0, 8);

    // Async reset mid-WAIT2: outputs clear before any edge, no event later.
    drive(1'b1, 2);
    drive(1'b0, 2);
    chk("wait2_busy", 32'(bus_if.busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", outs(), 0);
    drive(1'b0, 2);
    reset_n = 1'b1;
    drive(1'b0, 8);
    chk("post_reset_outs", outs(), 0);

    // Reset released with pb high: first edge starts a press.
    reset_n = 1'b0;
    drive(1'b1, 1);
    reset_n = 1'b1;
    b = cyc;
    push(K_LONG, b + 8);
    drive(1'b1, 8);
    drive(1'b0, 4);

    // en=0 mid-PRESS1: outputs zero after one edge, no event afterwards.
    drive(1'b1, 3);
    chk("press1_busy", 32'(bus_if.busy), 1);
    bus_if.en = 1'b0;
    drive(1'b1, 1);
    chk("disable_outs", outs(), 0);
    drive(1'b1, 8);
    chk("disabled_hold_outs", outs(), 0);
    // Re-enable with pb still high: new press, long after 8 edges.
    bus_if.en = 1'b1;
    b = cyc;
    push(K_LONG, b + 8);
    drive(1'b1, 8);
    drive(1'b0, 4);

    // en=0 mid-WAIT2 discards the pending short press.
    drive(1'b1, 2);
    drive(1'b0, 1);
    bus_if.en = 1'b0;
    drive(1'b0, 5);
    bus_if.en = 1'b1;
    drive(1'b0, 6);
    chk("wait2_disable_outs", outs(), 0);

    drive(1'b0, 4);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
